// File: rtl/bidir_cfg_loader_pkg.sv
// bidir_cfg_loader shared package: widths, sync word, states, index helper.
// Optional readback is enabled by defining CFG_READBACK_EN.
package bidir_cfg_pkg;

  localparam int CFG_W   = 108;
  localparam int SYNC_W  = 8;
  localparam int TRACKS  = 3;
  localparam int SLICE_W = 12;
  localparam int SIDE_W  = TRACKS * SLICE_W;
  localparam int CNT_W   = $clog2(CFG_W);
  localparam int RB_CW   = $clog2(CFG_W + 1);

  localparam logic [SYNC_W-1:0] SYNC_WORD = 8'hA5;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    LOAD   = 2'd1,
    PAR    = 2'd2,
    COMMIT = 2'd3
  } cfg_state_e;

  // Bit index of a switch select inside the cfg bus.
  function automatic int unsigned cfg_idx(
    input int unsigned side,
    input int unsigned track,
    input int unsigned sel
  );
    return side * SIDE_W + track * SLICE_W + sel;
  endfunction

endpackage

// File: rtl/bidir_cfg_loader_if.sv
// Serial bit stream handshake into the cfg loader.
// Optional readback is enabled by defining CFG_READBACK_EN.
interface bidir_cfg_loader_if;

  logic s_valid;
  logic s_bit;
  logic s_ready;

  modport master (
    output s_valid,
    output s_bit,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_bit,
    output s_ready
  );

endinterface

// File: rtl/bidir_cfg_rb_shift.sv
// Readback shifter: streams a snapshot of cfg out LSB first.
// Built only when CFG_READBACK_EN is defined.
module bidir_cfg_rb_shift
  import bidir_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CFG_W-1:0] data_i,
  output logic             rb_valid_o,
  output logic             rb_bit_o
);

  logic [CFG_W-1:0] sh_q, sh_d;
  logic [RB_CW-1:0] left_q, left_d;
  logic             active;

  assign active     = left_q != '0;
  assign rb_valid_o = active;
  assign rb_bit_o   = sh_q[0];

  // Snapshot on start, then one bit per cycle until empty.
  always_comb begin
    sh_d   = sh_q;
    left_d = left_q;
    if (active) begin
      sh_d   = {1'b0, sh_q[CFG_W-1:1]};
      left_d = left_q - 1'b1;
    end else if (start_i) begin
      sh_d   = data_i;
      left_d = RB_CW'(CFG_W);
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      left_q <= '0;
    end else begin
      sh_q   <= sh_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/bidir_cfg_loader.sv
// Serial cfg loader: sync hunt, shadow load, parity check, commit.
// Define CFG_READBACK_EN to add the rb_req/rb_valid/rb_bit readback port.
module bidir_cfg_loader
  import bidir_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  bidir_cfg_loader_if.slave s,
  output logic [CFG_W-1:0]  cfg,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err
`ifdef CFG_READBACK_EN
  ,
  input  logic              rb_req,
  output logic              rb_valid,
  output logic              rb_bit
`endif
);

  localparam logic [1:0] S_SYNC   = SYNC;
  localparam logic [1:0] S_LOAD   = LOAD;
  localparam logic [1:0] S_PAR    = PAR;
  localparam logic [1:0] S_COMMIT = COMMIT;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CFG_W-1:0]  shadow_q, shadow_d;
  logic [SYNC_W-1:0] sync_q, sync_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              acc;
  logic [SYNC_W-1:0] sync_nx;

  assign s.s_ready = state_q != S_COMMIT;
  assign acc       = s.s_valid && s.s_ready;
  assign sync_nx   = {sync_q[SYNC_W-2:0], s.s_bit};
  assign busy      = state_q != S_SYNC;
  assign cfg       = cfg_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

  // Frame FSM and shadow/cfg datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sync_d   = sync_q;
    cfg_d    = cfg_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (1'b1)
      state_q == S_SYNC: begin
        if (acc) begin
          sync_d = sync_nx;
          if (sync_nx == SYNC_WORD) begin
            state_d = S_LOAD;
            cnt_d   = '0;
          end
        end
      end
      state_q == S_LOAD: begin
        if (acc) begin
          shadow_d[cnt_q] = s.s_bit;
          if (cnt_q == CNT_W'(CFG_W - 1))
            state_d = S_PAR;
          else
            cnt_d = cnt_q + 1'b1;
        end
      end
      state_q == S_PAR: begin
        if (acc) begin
          if ((^shadow_q ^ s.s_bit) == 1'b0) begin
            state_d = S_COMMIT;
            cfg_d   = shadow_q;
            done_d  = 1'b1;
          end else begin
            state_d = S_SYNC;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        sync_d  = '0;
        state_d = S_SYNC;
      end
    endcase
  end

  // Loader state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_SYNC;
      cnt_q    <= '0;
      shadow_q <= '0;
      sync_q   <= '0;
      cfg_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sync_q   <= sync_d;
      cfg_q    <= cfg_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef CFG_READBACK_EN
  logic rb_start;

  assign rb_start = rb_req && (state_q == S_SYNC) && !rb_valid;

  bidir_cfg_rb_shift u_rb (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (rb_start),
    .data_i     (cfg_q),
    .rb_valid_o (rb_valid),
    .rb_bit_o   (rb_bit)
  );
`endif

endmodule

// File: tb/tb_bidir_cfg_loader.sv
// Directed bench for bidir_cfg_loader.
// Readback section runs when CFG_READBACK_EN is defined.
module tb_bidir_cfg_loader;
  import bidir_cfg_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [CFG_W-1:0] cfg;
  logic             busy;
  logic             cfg_done;
  logic             cfg_err;
`ifdef CFG_READBACK_EN
  logic             rb_req;
  logic             rb_valid;
  logic             rb_bit;
`endif

  bidir_cfg_loader_if s_if ();

  bidir_cfg_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s_if),
    .cfg      (cfg),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
`ifdef CFG_READBACK_EN
    ,
    .rb_req   (rb_req),
    .rb_valid (rb_valid),
    .rb_bit   (rb_bit)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int done_n = 0;
  int err_n  = 0;
  int both_n = 0;
  logic [CFG_W-1:0] cfg_at_done = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_done) begin
      done_n      <= done_n + 1;
      cfg_at_done <= cfg;
    end
    if (cfg_err) err_n <= err_n + 1;
    if (cfg_done && cfg_err) both_n <= both_n + 1;
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    int n;
    n = 0;
    while (!s_if.s_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) check("ready_timeout", 0, 1);
    s_if.s_valid = 1'b1;
    s_if.s_bit   = b;
    @(negedge clk);
    s_if.s_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_sync();
    logic [SYNC_W-1:0] sw;
    sw = SYNC_WORD;
    for (int i = SYNC_W - 1; i >= 0; i--) send_bit(sw[i], 0);
  endtask

  task automatic send_frame(input logic [CFG_W-1:0] pl, input logic p,
                            input bit rnd);
    send_sync();
    for (int i = 0; i < CFG_W; i++)
      send_bit(pl[i], rnd ? int'($urandom_range(0, 3)) : 0);
    send_bit(p, 0);
    repeat (4) @(negedge clk);
  endtask

  logic [CFG_W-1:0] p1, p2, p3, rb_got;
  logic [7:0]       noise;
  int               d0, e0, k;

  initial begin
    p1 = '0;
    p1[38] = 1'b1;
    p1[50] = 1'b1;
    p1[62] = 1'b1;
    p2 = '0;
    p2[0]   = 1'b1;
    p2[107] = 1'b1;
    p3 = p1;
    p3[20:13] = 8'hA5;
    noise = 8'b1101_0010;
    s_if.s_valid = 1'b0;
    s_if.s_bit   = 1'b0;
`ifdef CFG_READBACK_EN
    rb_req = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg", cfg, 0);
    check("rst_ready", s_if.s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    d0 = done_n;
    send_frame(p1, 1'b1, 0);
    check("good_done_cnt", done_n - d0, 1);
    check("good_cfg", cfg, p1);
    check("good_cfg_at_done", cfg_at_done, p1);
    check("good_busy", busy, 0);
    check("good_idx", cfg[cfg_idx(1, 1, 2)], 1);

`ifdef CFG_READBACK_EN
    rb_req = 1'b1;
    @(negedge clk);
    rb_req = 1'b0;
    k = 0;
    rb_got = '0;
    for (int i = 0; i < 200; i++) begin
      if (rb_valid) begin
        if (k < CFG_W) rb_got[k] = rb_bit;
        k++;
      end
      @(negedge clk);
    end
    check("rb_len", k, CFG_W);
    check("rb_data", rb_got, p1);
`endif

    d0 = done_n;
    e0 = err_n;
    send_frame(p1, 1'b0, 0);
    check("bad_err_cnt", err_n - e0, 1);
    check("bad_done_cnt", done_n - d0, 0);
    check("bad_cfg", cfg, p1);

    d0 = done_n;
    send_frame(p2, 1'b0, 0);
    check("p2_done_cnt", done_n - d0, 1);
    check("p2_cfg", cfg, p2);

    d0 = done_n;
    for (int i = 0; i < 8; i++) send_bit(noise[i], 0);
    send_frame(p3, 1'b1, 1);
    check("noise_done_cnt", done_n - d0, 1);
    check("noise_cfg", cfg, p3);

    send_sync();
    for (int i = 0; i < 40; i++) send_bit(p2[i], 0);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_cfg", cfg, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ready", s_if.s_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_n;
    send_frame(p1, 1'b1, 0);
    check("mrst_done_cnt", done_n - d0, 1);
    check("mrst_frame_cfg", cfg, p1);

    check("done_err_overlap", both_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
